sprite_scan_ctrl: RTL and testbench

Multi-sprite successor to the single-car draw state logic. Compares the VGA scan position against NUM_SPR sprite bounding boxes in parallel and resolves priority. Emits a registered draw flag, the winning sprite index and the sprite-local row/column for sprite ROM addressing. Also holds the game run/pause mode from keyboard keycodes and latches per-frame sprite collisions for the game logic.

---
 rtl/sprite_scan_ctrl_if.sv | 35 +++
 rtl/sprite_scan_ctrl.sv | 130 +++++++++++++
 tb/tb_sprite_scan_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_scan_ctrl_if.sv
// Scan-side bundle for sprite_scan_ctrl: sprite table, scan position and keycode in,
// draw/priority results, run mode and collision mask out.
interface sprite_scan_ctrl_if #(
    parameter int unsigned NUM_SPR = 4,
    parameter int unsigned SPR_W   = 40,
    parameter int unsigned SPR_H   = 78,
    parameter int unsigned COORD_W = 10
) ();
    localparam int unsigned IDX_W = $clog2(NUM_SPR);
    localparam int unsigned ROW_W = $clog2(SPR_H);
    localparam int unsigned COL_W = $clog2(SPR_W);

    logic [NUM_SPR*COORD_W-1:0] SprX;
    logic [NUM_SPR*COORD_W-1:0] SprY;
    logic [NUM_SPR-1:0]         SprEn;
    logic [COORD_W-1:0]         DrawX;
    logic [COORD_W-1:0]         DrawY;
    logic [7:0]                 keycode;
    logic                       DrawSpr;
    logic [IDX_W-1:0]           SprIdx;
    logic [ROW_W-1:0]           SprRow;
    logic [COL_W-1:0]           SprCol;
    logic                       Running;
    logic [NUM_SPR-1:0]         CollMask;

    modport master (
        output SprX, SprY, SprEn, DrawX, DrawY, keycode,
        input  DrawSpr, SprIdx, SprRow, SprCol, Running, CollMask
    );

    modport slave (
        input  SprX, SprY, SprEn, DrawX, DrawY, keycode,
        output DrawSpr, SprIdx, SprRow, SprCol, Running, CollMask
    );
endinterface

// File: rtl/sprite_scan_ctrl.sv
// Multi-sprite scan controller: parallel bounding-box hit test with fixed priority,
// registered draw/ROM-address outputs, keyboard run/pause mode and per-frame collision latch.
module sprite_scan_ctrl #(
    parameter int unsigned NUM_SPR   = 4,
    parameter int unsigned SPR_W     = 40,
    parameter int unsigned SPR_H     = 78,
    parameter int unsigned COORD_W   = 10,
    parameter logic [7:0]  START_KEY = 8'h15,
    parameter logic [7:0]  PAUSE_KEY = 8'h13
) (
    input  logic              Clk,
    input  logic              Reset_n,
    sprite_scan_ctrl_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_SPR);
    localparam int unsigned ROW_W = $clog2(SPR_H);
    localparam int unsigned COL_W = $clog2(SPR_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE
    } mode_e;

    mode_e              state_q, state_d;
    logic               run_q, run_d;
    logic               draw_q, draw_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [NUM_SPR-1:0] acc_q, acc_d;
    logic [NUM_SPR-1:0] coll_q, coll_d;
    logic               at00_q, at00_d;

    logic [NUM_SPR-1:0] hit;
    logic [NUM_SPR-1:0] coll_hit;
    logic [IDX_W-1:0]   win;
    logic [COORD_W-1:0] sel_x, sel_y;
    logic               found;
    logic               multi;
    logic               frame;

    // Right/bottom edges are formed one bit wider so boxes near the max coordinate clip instead of wrapping.
    for (genvar g = 0; g < NUM_SPR; g++) begin : g_hit
        logic [COORD_W-1:0] sx, sy;
        logic [COORD_W:0]   x_end, y_end;
        assign sx     = bus.SprX[g*COORD_W +: COORD_W];
        assign sy     = bus.SprY[g*COORD_W +: COORD_W];
        assign x_end  = {1'b0, sx} + (COORD_W+1)'(SPR_W);
        assign y_end  = {1'b0, sy} + (COORD_W+1)'(SPR_H);
        assign hit[g] = bus.SprEn[g]
                        && (bus.DrawX >= sx) && ({1'b0, bus.DrawX} < x_end)
                        && (bus.DrawY >= sy) && ({1'b0, bus.DrawY} < y_end);
    end

    always_comb begin
        win   = '0;
        sel_x = '0;
        sel_y = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_SPR; i++) begin
            if (hit[i] && !found) begin
                found = 1'b1;
                win   = IDX_W'(i);
                sel_x = bus.SprX[i*COORD_W +: COORD_W];
                sel_y = bus.SprY[i*COORD_W +: COORD_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.keycode == START_KEY) state_d = S_RUN;
            S_RUN:   if (bus.keycode == PAUSE_KEY) state_d = S_PAUSE;
            S_PAUSE: if (bus.keycode == START_KEY) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
        run_d = (state_d == S_RUN);

        draw_d = (|hit) && (state_q != S_IDLE);
        idx_d  = draw_d ? win : '0;
        row_d  = draw_d ? ROW_W'(bus.DrawY - sel_y) : '0;
        col_d  = draw_d ? COL_W'(bus.DrawX - sel_x) : '0;

        // Collision gating looks at the mode before any same-cycle key transition.
        multi    = |(hit & (hit - NUM_SPR'(1)));
        coll_hit = ((state_q == S_RUN) && multi) ? hit : '0;
        at00_d   = (bus.DrawX == '0) && (bus.DrawY == '0);
        frame    = at00_d && !at00_q;
        if (frame) begin
            coll_d = acc_q | coll_hit;
            acc_d  = '0;
        end else begin
            coll_d = coll_q;
            acc_d  = acc_q | coll_hit;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            run_q   <= 1'b0;
            draw_q  <= 1'b0;
            idx_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            acc_q   <= '0;
            coll_q  <= '0;
            at00_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            draw_q  <= draw_d;
            idx_q   <= idx_d;
            row_q   <= row_d;
            col_q   <= col_d;
            acc_q   <= acc_d;
            coll_q  <= coll_d;
            at00_q  <= at00_d;
        end
    end

    assign bus.DrawSpr  = draw_q;
    assign bus.SprIdx   = idx_q;
    assign bus.SprRow   = row_q;
    assign bus.SprCol   = col_q;
    assign bus.Running  = run_q;
    assign bus.CollMask = coll_q;
endmodule

// File: tb/tb_sprite_scan_ctrl.sv
// Scoreboard bench for sprite_scan_ctrl: a pixel-level reference model queues expected
// outputs per clock, a monitor compares them on the falling edge.
module tb_sprite_scan_ctrl;
    localparam logic [7:0] K_START = 8'h15;
    localparam logic [7:0] K_PAUSE = 8'h13;

    typedef struct packed {
        logic       draw;
        logic [1:0] idx;
        logic [6:0] row;
        logic [5:0] col;
        logic       run;
        logic [3:0] coll;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    sprite_scan_ctrl_if #(.NUM_SPR(4), .SPR_W(40), .SPR_H(78), .COORD_W(10)) bus ();

    sprite_scan_ctrl #(
        .NUM_SPR(4), .SPR_W(40), .SPR_H(78), .COORD_W(10),
        .START_KEY(K_START), .PAUSE_KEY(K_PAUSE)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    // Stimulus state
    int         sx[4];
    int         sy[4];
    logic [3:0] en;
    int         dx, dy;
    logic [7:0] key;

    // Reference model state: 0 idle, 1 run, 2 pause
    int         m_mode;
    logic [3:0] m_acc;
    logic [3:0] m_coll;
    bit         m_prev00;

    exp_t exp_q[$];

    function automatic void model_reset();
        m_mode   = 0;
        m_acc    = '0;
        m_coll   = '0;
        m_prev00 = 1'b0;
    endfunction

    function automatic exp_t model_step();
        exp_t       e;
        logic [3:0] h;
        int         w;
        bit         at00;
        logic [3:0] add;
        h = '0;
        w = -1;
        for (int i = 0; i < 4; i++) begin
            if (en[i] && dx >= sx[i] && dx < sx[i] + 40 && dy >= sy[i] && dy < sy[i] + 78) begin
                h[i] = 1'b1;
                if (w < 0) w = i;
            end
        end
        e = '0;
        e.draw = (h != 0) && (m_mode != 0);
        if (e.draw) begin
            e.idx = 2'(w);
            e.row = 7'(dy - sy[w]);
            e.col = 6'(dx - sx[w]);
        end
        add  = (m_mode == 1 && $countones(h) >= 2) ? h : 4'b0;
        at00 = (dx == 0) && (dy == 0);
        if (at00 && !m_prev00) begin
            m_coll = m_acc | add;
            m_acc  = '0;
        end else begin
            m_acc = m_acc | add;
        end
        m_prev00 = at00;
        if (key == K_START && m_mode != 1) m_mode = 1;
        else if (key == K_PAUSE && m_mode == 1) m_mode = 2;
        e.run  = (m_mode == 1);
        e.coll = m_coll;
        return e;
    endfunction

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            bus.SprX[i*10 +: 10] = 10'(sx[i]);
            bus.SprY[i*10 +: 10] = 10'(sy[i]);
        end
        bus.SprEn   = en;
        bus.DrawX   = 10'(dx);
        bus.DrawY   = 10'(dy);
        bus.keycode = key;
    endtask

    // One clock: apply inputs, queue the model's view of the next edge, return 1ns after it.
    task automatic cyc();
        drive();
        exp_q.push_back(model_step());
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_draw"}, int'(bus.DrawSpr), 0);
        chk({nm, "_idx"},  int'(bus.SprIdx), 0);
        chk({nm, "_row"},  int'(bus.SprRow), 0);
        chk({nm, "_col"},  int'(bus.SprCol), 0);
        chk({nm, "_run"},  int'(bus.Running), 0);
        chk({nm, "_coll"}, int'(bus.CollMask), 0);
    endtask

    // Monitor: anything queued before an edge belongs to that edge.
    initial begin
        int   n;
        exp_t e;
        exp_t a;
        forever begin
            @(posedge Clk);
            n = exp_q.size();
            @(negedge Clk);
            if (n > 0) begin
                e = exp_q.pop_front();
                a = {bus.DrawSpr, bus.SprIdx, bus.SprRow, bus.SprCol, bus.Running, bus.CollMask};
                n_tests++;
                if (a != e) begin
                    n_fail++;
                    $display("FAIL scoreboard @%0t: got draw=%0d idx=%0d row=%0d col=%0d run=%0d coll=%b expected draw=%0d idx=%0d row=%0d col=%0d run=%0d coll=%b",
                             $time, a.draw, a.idx, a.row, a.col, a.run, a.coll,
                             e.draw, e.idx, e.row, e.col, e.run, e.coll);
                end
            end
        end
    end

    initial begin
        bit clustered;
        int k;
        int r;
        Reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sx[i] = 0;
            sy[i] = 0;
        end
        en  = '0;
        dx  = 5;
        dy  = 5;
        key = 8'h00;
        drive();
        model_reset();
        #1 Reset_n = 1'b0;
        #1 chk_all_zero("reset");
        #1 Reset_n = 1'b1;

        // Start, then corner pixels of sprite 0
        key = K_START;
        cyc();
        chk("start_running", int'(bus.Running), 1);
        key = 8'h00;
        sx[0] = 100; sy[0] = 200; en = 4'b0001;
        dx = 100; dy = 200;
        cyc();
        cyc();
        chk("tl_draw", int'(bus.DrawSpr), 1);
        chk("tl_idx",  int'(bus.SprIdx), 0);
        chk("tl_row",  int'(bus.SprRow), 0);
        chk("tl_col",  int'(bus.SprCol), 0);
        dx = 139; dy = 277;
        cyc();
        chk("br_draw", int'(bus.DrawSpr), 1);
        chk("br_row",  int'(bus.SprRow), 77);
        chk("br_col",  int'(bus.SprCol), 39);
        dx = 140; dy = 277;
        cyc();
        chk("right_edge_draw", int'(bus.DrawSpr), 0);
        dx = 139; dy = 278;
        cyc();
        chk("bottom_edge_draw", int'(bus.DrawSpr), 0);

        // Overlap of sprites 1 and 2 in RUN
        sx[1] = 290; sy[1] = 40;
        sx[2] = 280; sy[2] = 30;
        en = 4'b0111;
        dx = 300; dy = 50;
        cyc();
        chk("overlap_idx", int'(bus.SprIdx), 1);
        chk("overlap_row", int'(bus.SprRow), 10);
        dx = 0; dy = 0;
        cyc();
        chk("frame_coll", int'(bus.CollMask), 4'b0110);
        dx = 5; dy = 5;
        cyc();
        chk("coll_holds", int'(bus.CollMask), 4'b0110);
        dx = 0; dy = 0;
        cyc();
        chk("clean_frame_coll", int'(bus.CollMask), 0);

        // Sprite near the coordinate maximum must clip, not wrap
        en = 4'b1000; sx[3] = 1000; sy[3] = 0;
        dy = 5;
        for (int x = 0; x < 16; x++) begin
            dx = x;
            cyc();
            if (x == 3) chk("no_wrap_draw", int'(bus.DrawSpr), 0);
        end
        for (int x = 990; x < 1024; x++) begin
            dx = x;
            cyc();
        end
        chk("clip_draw_1023", int'(bus.DrawSpr), 1);
        chk("clip_col_1023",  int'(bus.SprCol), 23);

        // Pause: drawing continues, collisions ignored
        dx = 0; dy = 0;
        cyc();
        key = K_PAUSE; dx = 7; dy = 7;
        cyc();
        chk("pause_running", int'(bus.Running), 0);
        key = 8'h00;
        en = 4'b0110;
        dx = 300; dy = 50;
        cyc();
        chk("pause_draw", int'(bus.DrawSpr), 1);
        dx = 0; dy = 0;
        cyc();
        chk("pause_coll", int'(bus.CollMask), 0);
        key = K_START; dx = 9; dy = 9;
        cyc();
        chk("resume_running", int'(bus.Running), 1);
        key = 8'h00;

        // Randomised phase
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 49) == 0) begin
                clustered = ($urandom_range(0, 3) != 0);
                for (int i = 0; i < 4; i++) begin
                    if (clustered) begin
                        sx[i] = $urandom_range(400, 460);
                        sy[i] = $urandom_range(300, 380);
                    end else begin
                        sx[i] = $urandom_range(0, 1023);
                        sy[i] = $urandom_range(0, 1023);
                    end
                end
                en = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 63) == 0) begin
                dx = 0; dy = 0;
            end else begin
                k  = $urandom_range(0, 3);
                dx = sx[k] + $urandom_range(0, 50) - 5;
                dy = sy[k] + $urandom_range(0, 90) - 5;
                if (dx < 0) dx = 0;
                if (dx > 1023) dx = 1023;
                if (dy < 0) dy = 0;
                if (dy > 1023) dy = 1023;
            end
            r = $urandom_range(0, 31);
            if (r == 0) key = K_START;
            else if (r == 1) key = K_PAUSE;
            else if (r == 2) key = 8'($urandom_range(0, 255));
            else key = 8'h00;
            cyc();
        end

        // Mid-line reset while drawing
        key = K_START; en = 4'b0001; sx[0] = 100; sy[0] = 200;
        dx = 110; dy = 210;
        cyc();
        key = 8'h00;
        cyc();
        chk("pre_reset_draw", int'(bus.DrawSpr), 1);
        #5 Reset_n = 1'b0;
        model_reset();
        #1 chk_all_zero("midline_reset");
        #1 Reset_n = 1'b1;
        cyc();
        chk("post_reset_idle_draw", int'(bus.DrawSpr), 0);
        dx = 111;
        cyc();
        chk("post_reset_idle_draw2", int'(bus.DrawSpr), 0);
        key = K_START;
        cyc();
        key = 8'h00;
        cyc();
        chk("restart_draw", int'(bus.DrawSpr), 1);
        chk("restart_col",  int'(bus.SprCol), 11);

        @(negedge Clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
